pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Parametrised program-counter sequencer for the pipelined core. Holds the word-addressed fetch PC and supplies it to instruction memory.
- Handles external load, stall, branch/jump resolution after a configurable resolve latency, and halt. Unlike the earlier PC block, halt is restartable.
- Branch offsets are sign-extended. Stalls freeze the resolve countdown.

Parameters:
- AW, 32: PC width in bits (word address), 8..32.
- RESOLVE_LAT, 1: cycles from jump_det to branch resolution, 1..3.
- RESET_PC, 0: PC value after reset, AW bits.

Ports:
- clk  in  1  clock, rising edge.
- rstd  in  1  reset, asynchronous, active-low.
- stall  in  1  hold PC and state this cycle.
- load_en  in  1  force PC load.
- load_addr  in  32  byte address; PC <= load_addr[AW+1:2].
- jump_det  in  1  control-flow instruction detected in decode; start resolve wait.
- op  in  6  opcode of resolving instruction.
- os  in  32  source operand s.
- ot  in  32  source operand t.
- imm_dpl  in  32  byte displacement, signed.
- pc_in  in  AW  PC of resolving instruction.
- restart  in  1  leave HALT.
- pc_out  out  AW  current fetch PC.
- halted  out  1  state==HALT.
- resolving  out  1  state==WAIT.
- taken  out  1  registered, one-cycle pulse: previous cycle resolved to a non-fallthrough target.

Behaviour:
- Reset (async, rstd=0): pc=RESET_PC, state=RUN, cnt=0, taken=0. halted and resolving are 0.
- All updates occur on the rising clk edge. pc_out is the pc register, with zero combinational path.
- Resolve arithmetic, all values truncated to AW:
  - nonbranch = pc_in+1.
  - branch = nonbranch + (imm_dpl >>> 2), arithmetic shift.
- npc by op:
  - 32: branch if os==ot, else nonbranch.
  - 33: branch if os!=ot, else nonbranch.
  - 34: branch if os<ot, else nonbranch.
  - 35: branch if os<=ot, else nonbranch.
  - 42: os[AW-1:0].
  - other: nonbranch.
  - All compares are unsigned, 32-bit.
- State RUN, priority order:
  1. load_en: pc<=load_addr>>2.
  2. stall: hold.
  3. op==63 and !jump_det: pc<=pc_in, go HALT.
  4. else pc<=pc+1.
  - Additionally, if jump_det and !load_en and !stall: go WAIT, cnt<=RESOLVE_LAT. pc takes the rule-4 value that cycle.
- State WAIT:
  - load_en: pc<=load_addr>>2, cnt<=0, go RUN. The pending resolve is aborted.
  - stall: pc and cnt hold.
  - cnt==1: pc<=npc, cnt<=0, go RUN. taken<=1 next cycle iff npc!=nonbranch.
  - cnt>1: pc holds, cnt<=cnt-1. The fetch bubble is owned by downstream.
  - jump_det and op==63 are ignored in WAIT.
- State HALT:
  - load_en: pc<=load_addr>>2, go RUN.
  - else restart: pc<=pc+1, go RUN.
  - else hold. stall and jump_det are ignored.
- taken defaults to 0 each cycle. It is never asserted outside the cycle after a WAIT resolve.
- PC increment wraps modulo 2^AW with no flag.
- Counter cnt is 2 bits; RESOLVE_LAT=0 or >3 is illegal, and a simulation assertion is required.
- Reset asserted mid-WAIT or mid-HALT returns to RUN/RESET_PC immediately, asynchronously.

Test Plan:
- Reset then 4 free cycles, AW=32 -> pc_out sequence 0,1,2,3,4. halted=0, resolving=0.
- RESOLVE_LAT=1: jump_det at pc=5; next cycle op=32, os=ot=7, pc_in=5, imm_dpl=-8 -> pc_out=4 after resolve, taken=1 for one cycle. Repeat with os!=ot -> pc_out=6, taken=0.
- RESOLVE_LAT=3: jump_det at pc=10 -> pc 11 held 2 cycles. Stall in the middle extends the hold by 1. Resolve op=42, os=0x40 -> pc_out=0x40.
- op=63 with pc_in=20 -> pc_out=20, halted=1, held 5 cycles despite stall/jump_det. Then restart -> pc_out=21, halted=0.
- load_en during WAIT, load_addr=0x200 -> pc_out=0x80, resolving=0, and no later resolve. load_en with stall in RUN -> load wins.
- AW=8: pc=0xFF incremented -> 0x00. Async reset asserted mid-WAIT -> pc_out=RESET_PC without a clock edge.

Source files
------------

// File: rtl/pc_seq.sv
// Fetch program-counter sequencer: load, stall, delayed branch/jump resolution and restartable halt.
// pc_out is driven straight from the PC register; all control is resolved one edge ahead.
module pc_seq #(
   parameter int              AW          = 32,
   parameter int              RESOLVE_LAT = 1,
   parameter logic [AW-1:0]   RESET_PC    = '0
) (
   input  logic          clk,
   input  logic          rstd,
   input  logic          stall,
   input  logic          load_en,
   input  logic [31:0]   load_addr,
   input  logic          jump_det,
   input  logic [5:0]    op,
   input  logic [31:0]   os,
   input  logic [31:0]   ot,
   input  logic [31:0]   imm_dpl,
   input  logic [AW-1:0] pc_in,
   input  logic          restart,
   output logic [AW-1:0] pc_out,
   output logic          halted,
   output logic          resolving,
   output logic          taken
);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [5:0]    OP_BEQ  = 6'd32;
   localparam logic [5:0]    OP_BNE  = 6'd33;
   localparam logic [5:0]    OP_BLT  = 6'd34;
   localparam logic [5:0]    OP_BLE  = 6'd35;
   localparam logic [5:0]    OP_JR   = 6'd42;
   localparam logic [5:0]    OP_HALT = 6'd63;
   localparam logic [1:0]    LAT_CNT = 2'(RESOLVE_LAT);
   localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          taken_q, taken_d;

   logic [31:0]   load_word;
   logic [31:0]   imm_word;
   logic [AW-1:0] load_pc;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] nonbranch;
   logic [AW-1:0] branch;
   logic [AW-1:0] npc;
   logic          unused_bits;

   // Byte addresses and displacements become word quantities before truncation to AW.
   assign load_word = {2'b00, load_addr[31:2]};
   assign imm_word  = 32'($signed(imm_dpl) >>> 2);
   assign load_pc   = load_word[AW-1:0];
   assign pc_inc    = pc_q + PC_ONE;
   assign nonbranch = pc_in + PC_ONE;
   assign branch    = nonbranch + imm_word[AW-1:0];
   assign unused_bits = ^{load_word, imm_word, os};

   always_comb begin
      npc = nonbranch;
      case (op)
         OP_BEQ:  if (os == ot) npc = branch;
         OP_BNE:  if (os != ot) npc = branch;
         OP_BLT:  if (os <  ot) npc = branch;
         OP_BLE:  if (os <= ot) npc = branch;
         OP_JR:   npc = os[AW-1:0];
         default: npc = nonbranch;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      taken_d = 1'b0;
      case (state_q)
         S_RUN: begin
            if (load_en) begin
               pc_d = load_pc;
            end else if (!stall) begin
               if (op == OP_HALT && !jump_det) begin
                  pc_d    = pc_in;
                  state_d = S_HALT;
               end else begin
                  pc_d = pc_inc;
                  if (jump_det) begin
                     state_d = S_WAIT;
                     cnt_d   = LAT_CNT;
                  end
               end
            end
         end
         S_WAIT: begin
            // A load aborts the pending resolve outright.
            if (load_en) begin
               pc_d    = load_pc;
               cnt_d   = 2'd0;
               state_d = S_RUN;
            end else if (!stall) begin
               if (cnt_q <= 2'd1) begin
                  pc_d    = npc;
                  cnt_d   = 2'd0;
                  state_d = S_RUN;
                  taken_d = (npc != nonbranch);
               end else begin
                  cnt_d = cnt_q - 2'd1;
               end
            end
         end
         S_HALT: begin
            if (load_en) begin
               pc_d    = load_pc;
               state_d = S_RUN;
            end else if (restart) begin
               pc_d    = pc_inc;
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_RUN;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= 2'd0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         taken_q <= taken_d;
      end
   end

   // The 2-bit countdown only covers latencies 1..3.
   always @(posedge clk) begin
      assert (RESOLVE_LAT >= 1 && RESOLVE_LAT <= 3)
         else $error("pc_seq: RESOLVE_LAT=%0d outside 1..3", RESOLVE_LAT);
   end

   assign pc_out    = pc_q;
   assign halted    = (state_q == S_HALT);
   assign resolving = (state_q == S_WAIT);
   assign taken     = taken_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: three instances (latency 1, latency 3, 8-bit PC) share one stimulus
// bus and are released from reset individually; each section checks one instance.
module tb_pc_seq;

   logic        clk = 1'b0;
   logic        rstd1, rstd3, rstd8;
   logic        stall, load_en, jump_det, restart;
   logic [31:0] load_addr, os, ot, imm_dpl, pc_in;
   logic [7:0]  pc_in8;
   logic [5:0]  op;

   logic [31:0] pc1, pc3;
   logic [7:0]  pc8;
   logic        halted1, resolving1, taken1;
   logic        halted3, resolving3, taken3;
   logic        halted8, resolving8, taken8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_seq #(.AW(32), .RESOLVE_LAT(1), .RESET_PC(32'h0)) u_lat1 (
      .clk(clk), .rstd(rstd1), .stall(stall), .load_en(load_en), .load_addr(load_addr),
      .jump_det(jump_det), .op(op), .os(os), .ot(ot), .imm_dpl(imm_dpl), .pc_in(pc_in),
      .restart(restart), .pc_out(pc1), .halted(halted1), .resolving(resolving1), .taken(taken1)
   );

   pc_seq #(.AW(32), .RESOLVE_LAT(3), .RESET_PC(32'h0)) u_lat3 (
      .clk(clk), .rstd(rstd3), .stall(stall), .load_en(load_en), .load_addr(load_addr),
      .jump_det(jump_det), .op(op), .os(os), .ot(ot), .imm_dpl(imm_dpl), .pc_in(pc_in),
      .restart(restart), .pc_out(pc3), .halted(halted3), .resolving(resolving3), .taken(taken3)
   );

   pc_seq #(.AW(8), .RESOLVE_LAT(1), .RESET_PC(8'h0)) u_aw8 (
      .clk(clk), .rstd(rstd8), .stall(stall), .load_en(load_en), .load_addr(load_addr),
      .jump_det(jump_det), .op(op), .os(os), .ot(ot), .imm_dpl(imm_dpl), .pc_in(pc_in8),
      .restart(restart), .pc_out(pc8), .halted(halted8), .resolving(resolving8), .taken(taken8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) begin
         $display("[TB] %s observed=%0h", tag, obs);
      end else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstd1 = 1'b0; rstd3 = 1'b0; rstd8 = 1'b0;
      stall = 1'b0; load_en = 1'b0; jump_det = 1'b0; restart = 1'b0;
      load_addr = 32'h0; os = 32'h0; ot = 32'h0; imm_dpl = 32'h0; pc_in = 32'h0;
      pc_in8 = 8'h0; op = 6'd0;

      // Reset state and free-running increment
      #2;
      check("rst_pc", pc1, 32'd0);
      check("rst_halted", 32'(halted1), 32'd0);
      check("rst_resolving", 32'(resolving1), 32'd0);
      check("rst_taken", 32'(taken1), 32'd0);
      rstd1 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("run_pc%0d", i), pc1, 32'(i));
      end
      step();
      check("run_pc5", pc1, 32'd5);

      // BEQ taken, latency 1: target 6 + (-8>>>2) = 4
      jump_det = 1'b1;
      step();
      check("beq_wait_pc", pc1, 32'd6);
      check("beq_resolving", 32'(resolving1), 32'd1);
      jump_det = 1'b0; op = 6'd32; os = 32'd7; ot = 32'd7; pc_in = 32'd5; imm_dpl = 32'hFFFF_FFF8;
      step();
      check("beq_taken_pc", pc1, 32'd4);
      check("beq_taken", 32'(taken1), 32'd1);
      check("beq_resolved", 32'(resolving1), 32'd0);
      op = 6'd0;
      step();
      check("beq_after_pc", pc1, 32'd5);
      check("beq_taken_pulse", 32'(taken1), 32'd0);

      // BEQ not taken: falls through to 6
      jump_det = 1'b1;
      step();
      check("bne_wait_pc", pc1, 32'd6);
      jump_det = 1'b0; op = 6'd32; os = 32'd7; ot = 32'd8; pc_in = 32'd5;
      step();
      check("beq_nt_pc", pc1, 32'd6);
      check("beq_nt_taken", 32'(taken1), 32'd0);

      // BLT is unsigned: 1 < 0xFFFFFFFF, target 8 + 16/4 = 12
      op = 6'd0;
      step();
      check("blt_pre_pc", pc1, 32'd7);
      jump_det = 1'b1;
      step();
      jump_det = 1'b0; op = 6'd34; os = 32'd1; ot = 32'hFFFF_FFFF; pc_in = 32'd7; imm_dpl = 32'd16;
      step();
      check("blt_pc", pc1, 32'd12);
      check("blt_taken", 32'(taken1), 32'd1);

      // HALT at pc_in=20, ignores stall and jump_det, then restart
      op = 6'd63; pc_in = 32'd20;
      step();
      check("halt_pc", pc1, 32'd20);
      check("halt_flag", 32'(halted1), 32'd1);
      stall = 1'b1; jump_det = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("halt_hold%0d", i), pc1, 32'd20);
      end
      check("halt_still", 32'(halted1), 32'd1);
      check("halt_no_wait", 32'(resolving1), 32'd0);
      stall = 1'b0; jump_det = 1'b0; restart = 1'b1; op = 6'd0;
      step();
      restart = 1'b0;
      check("restart_pc", pc1, 32'd21);
      check("restart_halted", 32'(halted1), 32'd0);

      // Load during WAIT aborts the resolve
      jump_det = 1'b1;
      step();
      check("ldw_wait_pc", pc1, 32'd22);
      jump_det = 1'b0; load_en = 1'b1; load_addr = 32'h200; op = 6'd42; os = 32'h1234;
      step();
      load_en = 1'b0; op = 6'd0;
      check("ldw_pc", pc1, 32'h80);
      check("ldw_resolving", 32'(resolving1), 32'd0);
      step();
      check("ldw_no_resolve", pc1, 32'h81);
      check("ldw_no_taken", 32'(taken1), 32'd0);

      // Load beats stall in RUN
      stall = 1'b1; load_en = 1'b1; load_addr = 32'h40;
      step();
      stall = 1'b0; load_en = 1'b0;
      check("ld_stall_pc", pc1, 32'h10);

      // Latency 3 with a stall in the middle of the wait, resolved by JR
      rstd3 = 1'b1;
      load_en = 1'b1; load_addr = 32'd40;
      step();
      load_en = 1'b0;
      check("l3_load_pc", pc3, 32'd10);
      jump_det = 1'b1;
      step();
      jump_det = 1'b0;
      check("l3_wait_pc", pc3, 32'd11);
      check("l3_resolving", 32'(resolving3), 32'd1);
      step();
      check("l3_hold1", pc3, 32'd11);
      stall = 1'b1;
      step();
      stall = 1'b0;
      check("l3_hold_stall", pc3, 32'd11);
      check("l3_still_wait", 32'(resolving3), 32'd1);
      step();
      check("l3_hold2", pc3, 32'd11);
      check("l3_no_early_taken", 32'(taken3), 32'd0);
      op = 6'd42; os = 32'h40; pc_in = 32'd10;
      step();
      op = 6'd0;
      check("l3_jr_pc", pc3, 32'h40);
      check("l3_jr_taken", 32'(taken3), 32'd1);
      check("l3_resolved", 32'(resolving3), 32'd0);

      // AW=8 wrap and asynchronous reset mid-WAIT
      rstd8 = 1'b1;
      load_en = 1'b1; load_addr = 32'h3FC;
      step();
      load_en = 1'b0;
      check("aw8_load", 32'(pc8), 32'hFF);
      step();
      check("aw8_wrap", 32'(pc8), 32'h00);
      jump_det = 1'b1;
      step();
      jump_det = 1'b0;
      check("aw8_wait_pc", 32'(pc8), 32'h01);
      check("aw8_resolving", 32'(resolving8), 32'd1);
      #2;
      rstd8 = 1'b0;
      #1;
      check("aw8_async_pc", 32'(pc8), 32'h00);
      check("aw8_async_run", 32'(resolving8), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
